// File: rtl/led_step_ctrl.sv
// Step-enable generator for the 8-LED fill chaser: debounced run/pause
// toggle plus a one-cycle SS strobe every (BASE_DIV << SPEED) cycles.
// Ports: Clk, RST (async, active-high), BTN_SS (raw button),
//   SPEED[1:0] (rate select), SS (step strobe), RUN (running),
//   BTN_PRESS (accepted press pulse). All outputs are registered.
module led_step_ctrl #(
  parameter int DEB_CYCLES = 250000,
  parameter int BASE_DIV   = 5000000,
  parameter bit AUTO_RUN   = 1'b0
) (
  input  logic       Clk,
  input  logic       RST,
  input  logic       BTN_SS,
  input  logic [1:0] SPEED,
  output logic       SS,
  output logic       RUN,
  output logic       BTN_PRESS
);

  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int PW = $clog2(BASE_DIV * 8);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUNNING,
    PAUSED
  } state_t;

  localparam state_t RST_STATE = AUTO_RUN ? RUNNING : IDLE;

  state_t        state;
  logic          sync1;
  logic          sync2;
  logic          db;
  logic          db_q;
  logic [DW-1:0] dcnt;
  logic [PW-1:0] pcnt;
  logic [31:0]   limit;
  logic          press;
  logic          term;

  // press is the internal pulse the cycle after db rises
  assign press = db & ~db_q;

  // >= so a lowered period wraps at once instead of rolling over
  assign limit = (32'(BASE_DIV) << SPEED) - 32'd1;
  assign term  = 32'(pcnt) >= limit;

  always_ff @(posedge Clk or posedge RST) begin
    if (RST) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      db        <= 1'b0;
      db_q      <= 1'b0;
      dcnt      <= '0;
      pcnt      <= '0;
      SS        <= 1'b0;
      BTN_PRESS <= 1'b0;
      state     <= RST_STATE;
      RUN       <= AUTO_RUN;
    end else begin
      sync1     <= BTN_SS;
      sync2     <= sync1;
      db_q      <= db;
      BTN_PRESS <= press;
      SS        <= 1'b0;

      if (sync2 == db) begin
        dcnt <= '0;
      end else if (dcnt == DEB_LAST) begin
        db   <= sync2;
        dcnt <= '0;
      end else begin
        dcnt <= dcnt + DW'(1);
      end

      case (state)
        IDLE: begin
          if (press) begin
            state <= RUNNING;
            RUN   <= 1'b1;
            pcnt  <= '0;
          end
        end
        RUNNING: begin
          pcnt <= term ? '0 : pcnt + PW'(1);
          // a press on the terminal edge suppresses the strobe
          SS   <= term & ~press;
          if (press) begin
            state <= PAUSED;
            RUN   <= 1'b0;
          end
        end
        PAUSED: begin
          if (press) begin
            state <= RUNNING;
            RUN   <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          RUN   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_step_ctrl.sv
// Scoreboard bench for led_step_ctrl: stimulus queues expected strobe
// cycles, a negedge monitor pops and compares on every SS/BTN_PRESS pulse.
module tb_led_step_ctrl;

  logic       Clk = 1'b0;
  logic       RST;
  logic       BTN_SS;
  logic [1:0] SPEED;
  logic       SS;
  logic       RUN;
  logic       BTN_PRESS;
  logic [7:0] led;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ss_q[$];
  int pr_q[$];

  int p;
  int n2;
  int n3;
  int n4;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  led_step_ctrl #(
    .DEB_CYCLES(4),
    .BASE_DIV(10),
    .AUTO_RUN(1'b0)
  ) dut (
    .Clk(Clk),
    .RST(RST),
    .BTN_SS(BTN_SS),
    .SPEED(SPEED),
    .SS(SS),
    .RUN(RUN),
    .BTN_PRESS(BTN_PRESS)
  );

  // chaser driven by the strobe
  always @(posedge Clk or posedge RST) begin
    if (RST) led <= 8'h80;
    else if (SS) led <= (led == 8'hFF) ? 8'h80 : {1'b1, led[7:1]};
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (SS === 1'b1) begin
      if (ss_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL ss_unexpected actual=cyc%0d required=none", cyc);
      end else begin
        chk("ss_cycle", cyc, ss_q.pop_front());
      end
    end
    if (BTN_PRESS === 1'b1) begin
      if (pr_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL press_unexpected actual=cyc%0d required=none", cyc);
      end else begin
        chk("press_cycle", cyc, pr_q.pop_front());
      end
    end
  end

  // returns 1 time unit after edge t
  task automatic wait_to(int t);
    while (cyc < t) begin
      @(posedge Clk);
      #1;
    end
  endtask

  // high for 8 cycles; pulse expected 7 edges after it goes high
  task automatic press();
    int t0;
    t0 = cyc;
    pr_q.push_back(t0 + 7);
    BTN_SS = 1'b1;
    wait_to(t0 + 8);
    BTN_SS = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    BTN_SS = 1'b0;
    SPEED = 2'd0;
    wait_to(3);
    chk("rst_ss", 32'(SS), 0);
    chk("rst_run", 32'(RUN), 0);
    chk("rst_press", 32'(BTN_PRESS), 0);
    RST = 1'b0;
    wait_to(cyc + 100);
    chk("idle_run", 32'(RUN), 0);

    BTN_SS = 1'b1;
    wait_to(cyc + 3);
    BTN_SS = 1'b0;
    wait_to(cyc + 20);
    chk("glitch_run", 32'(RUN), 0);

    p = cyc + 7;
    press();
    chk("start_run", 32'(RUN), 1);
    for (int k = 1; k <= 5; k++) ss_q.push_back(p + 10 * k);
    wait_to(p + 50);
    SPEED = 2'd2;
    ss_q.push_back(p + 90);
    ss_q.push_back(p + 130);
    wait_to(p + 130);
    SPEED = 2'd3;
    ss_q.push_back(p + 210);
    ss_q.push_back(p + 290);
    wait_to(p + 340);
    SPEED = 2'd0;
    for (int k = 0; k < 4; k++) ss_q.push_back(p + 341 + 10 * k);

    wait_to(p + 370);
    press();
    chk("pause_run", 32'(RUN), 0);
    chk("pause_led", 32'(led), 32'hFC);

    n2 = p + 577;
    wait_to(n2);
    chk("paused_run", 32'(RUN), 0);
    chk("paused_led", 32'(led), 32'hFC);
    for (int k = 0; k < 3; k++) ss_q.push_back(n2 + 11 + 10 * k);
    press();
    chk("resume_run", 32'(RUN), 1);

    n3 = n2 + 34;
    wait_to(n3);
    press();
    chk("collide_run", 32'(RUN), 0);

    n4 = n3 + 40;
    wait_to(n4);
    ss_q.push_back(n4 + 17);
    ss_q.push_back(n4 + 27);
    press();
    wait_to(n4 + 37);
    chk("pre_rst_ss", 32'(SS), 1);
    chk("pre_rst_led", 32'(led), 32'hE0);
    RST = 1'b1;
    #1;
    chk("async_ss", 32'(SS), 0);
    chk("async_run", 32'(RUN), 0);
    chk("async_press", 32'(BTN_PRESS), 0);
    wait_to(cyc + 2);
    RST = 1'b0;
    wait_to(cyc + 100);
    chk("post_rst_run", 32'(RUN), 0);
    chk("ss_left", ss_q.size(), 0);
    chk("press_left", pr_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
